// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// geometry defaults, derived address-field widths and FSM states.
package instruction_cache_pkg;

  localparam int ICACHE_LINE_COUNT     = 16;
  localparam int ICACHE_WORDS_PER_LINE = 4;

  localparam int ICACHE_OFFSET_W = $clog2(ICACHE_WORDS_PER_LINE);
  localparam int ICACHE_INDEX_W  = $clog2(ICACHE_LINE_COUNT);
  localparam int ICACHE_TAG_W    = 32 - 2 - ICACHE_OFFSET_W - ICACHE_INDEX_W;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/instruction_cache_store.sv
// Valid/tag/data arrays of the instruction cache: one combinational read
// port, one word write port with tag update, and a whole-cache flush.
module instruction_cache_store
  import instruction_cache_pkg::*;
#(
  parameter int LINE_COUNT     = ICACHE_LINE_COUNT,
  parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
  localparam int OW = $clog2(WORDS_PER_LINE),
  localparam int IW = $clog2(LINE_COUNT),
  localparam int TW = 32 - 2 - OW - IW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_word,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_offset,
  input  logic [31:0]   wr_word,
  input  logic          tag_en,
  input  logic [TW-1:0] tag_value,
  input  logic          set_valid
);

  logic [LINE_COUNT-1:0] valid;
  logic [TW-1:0]         tags  [LINE_COUNT];
  logic [31:0]           words [LINE_COUNT][WORDS_PER_LINE];

  // Flush wins over a same-edge valid set so a flushed fill never goes live.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         valid <= '0;
    else if (flush)     valid <= '0;
    else if (set_valid) valid[wr_index] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_en)  words[wr_index][wr_offset] <= wr_word;
    if (tag_en) tags[wr_index] <= tag_value;
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = words[rd_index][rd_offset];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path to the
// cpu ROM port, stall on miss, and a burst line fill from the memory bus.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int LINE_COUNT     = ICACHE_LINE_COUNT,
  parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        chip_enable,
  input  logic [31:0] address,
  output logic [31:0] data,
  output logic        stall_request,
  input  logic        flush,
  output logic        mem_request,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINE_COUNT);
  localparam int TW = 32 - 2 - OW - IW;

  icache_state_e    state, state_next;
  logic [OW-1:0]    beat, beat_next;
  logic [TW+IW-1:0] base, base_next;
  logic             flushed, flushed_next;

  logic [IW-1:0] addr_index;
  logic [OW-1:0] addr_offset;
  logic [TW-1:0] addr_tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_word;
  logic          hit, accept, last_beat;

  assign addr_offset = address[2 +: OW];
  assign addr_index  = address[OW+2 +: IW];
  assign addr_tag    = address[31 -: TW];

  assign hit       = chip_enable && rd_valid && (rd_tag == addr_tag) && (state == ICACHE_IDLE);
  assign accept    = (state == ICACHE_FILL) && mem_ready;
  assign last_beat = (beat == OW'(WORDS_PER_LINE - 1));

  instruction_cache_store #(
    .LINE_COUNT     (LINE_COUNT),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) store (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .rd_index  (addr_index),
    .rd_offset (addr_offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_en     (accept),
    .wr_index  (base[IW-1:0]),
    .wr_offset (beat),
    .wr_word   (mem_data),
    .tag_en    (accept && last_beat),
    .tag_value (base[TW+IW-1:IW]),
    .set_valid (accept && last_beat && !flush && !flushed)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ICACHE_IDLE;
      beat    <= '0;
      flushed <= 1'b0;
    end else begin
      state   <= state_next;
      beat    <= beat_next;
      flushed <= flushed_next;
    end
  end

  // Line base is pure data; outputs that expose it are state-gated.
  always_ff @(posedge clock) base <= base_next;

  always_comb begin
    state_next   = state;
    beat_next    = beat;
    base_next    = base;
    flushed_next = flushed;
    case (state)
      ICACHE_IDLE: begin
        if (chip_enable && !hit) begin
          state_next   = ICACHE_FILL;
          beat_next    = '0;
          base_next    = address[31:OW+2];
          flushed_next = 1'b0;
        end
      end
      ICACHE_FILL: begin
        if (flush) flushed_next = 1'b1;
        if (mem_ready) begin
          beat_next = beat + 1'b1;
          if (last_beat) state_next = ICACHE_IDLE;
        end
      end
      default: state_next = ICACHE_IDLE;
    endcase
  end

  assign mem_request   = (state == ICACHE_FILL);
  assign mem_address   = mem_request ? {base, beat, 2'b00} : 32'h0;
  // Held reset silences the cpu-facing outputs even with a fetch pending.
  assign stall_request = reset && ((state == ICACHE_FILL) || (chip_enable && !hit));
  assign data          = (reset && hit) ? rd_word : 32'h0;

endmodule
